// File: rtl/fpcvt_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | fpcvt_pipe                                                                |
// | Three-stage two's-complement to (S, E, F) float converter, valid/ready.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fpcvt_pipe #(
  parameter int W  = 12,
  parameter int EW = 3,
  parameter int FW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  D,
  input  logic          rnd_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          S,
  output logic [EW-1:0] E,
  output logic [FW-1:0] F,
  output logic          sat,
  output logic [CW-1:0] sat_cnt,
  input  logic          clr
);

  localparam int c_span = 1 << EW;
  localparam int c_lzw  = $clog2(W + 1);

  generate
    if (W != FW + c_span) begin : g_param_check
      $error("fpcvt_pipe: W must equal FW + 2**EW");
    end
  endgenerate

  // One enable moves every stage, so bubbles stay where they are.
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // ---------------- stage 1: sign / magnitude ----------------
  logic          r_v1, r_s1, r_psat1, r_rnd1;
  logic [W-1:0]  r_mag1;
  logic [W-1:0]  w_neg;
  logic          w_min;

  assign w_neg = -D;
  assign w_min = (D == {1'b1, {(W-1){1'b0}}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_s1    <= 1'b0;
      r_psat1 <= 1'b0;
      r_rnd1  <= 1'b0;
      r_mag1  <= '0;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_s1    <= D[W-1];
      r_rnd1  <= rnd_en;
      r_psat1 <= w_min;
      r_mag1  <= w_min ? {1'b0, {(W-1){1'b1}}} : (D[W-1] ? w_neg : D);
    end
  end

  // ---------------- stage 2: normalise ----------------
  logic [c_lzw-1:0] w_lz;
  logic [FW:0]      w_top;
  logic [EW-1:0]    w_e2;
  logic [FW-1:0]    w_f2;
  logic             w_r2;

  always_comb begin
    w_lz = c_lzw'(W);
    for (int i = 0; i < W; i++) begin
      if (r_mag1[i]) w_lz = c_lzw'(W - 1 - i);
    end
  end

  // Leading one plus FW-1 significand bits plus the round bit.
  assign w_top = (FW+1)'((r_mag1 << w_lz) >> (W - 1 - FW));

  always_comb begin
    if (int'(w_lz) >= c_span) begin
      w_e2 = '0;
      w_f2 = r_mag1[FW-1:0];
      w_r2 = 1'b0;
    end else begin
      w_e2 = EW'(c_span - int'(w_lz));
      w_f2 = w_top[FW:1];
      w_r2 = w_top[0];
    end
  end

  logic          r_v2, r_s2, r_r2, r_psat2, r_rnd2;
  logic [EW-1:0] r_e2;
  logic [FW-1:0] r_f2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_s2    <= 1'b0;
      r_e2    <= '0;
      r_f2    <= '0;
      r_r2    <= 1'b0;
      r_psat2 <= 1'b0;
      r_rnd2  <= 1'b0;
    end else if (w_adv) begin
      r_v2    <= r_v1;
      r_s2    <= r_s1;
      r_e2    <= w_e2;
      r_f2    <= w_f2;
      r_r2    <= w_r2;
      r_psat2 <= r_psat1;
      r_rnd2  <= r_rnd1;
    end
  end

  // ---------------- stage 3: round / saturate ----------------
  logic [FW:0]   w_fsum;
  logic [EW:0]   w_esum;
  logic [FW-1:0] w_f3;
  logic          w_sat3;

  assign w_fsum = {1'b0, r_f2} + {{FW{1'b0}}, r_rnd2 & r_r2};

  always_comb begin
    w_esum = {1'b0, r_e2};
    w_f3   = w_fsum[FW-1:0];
    if (w_fsum[FW]) begin
      w_f3   = {1'b1, {(FW-1){1'b0}}};
      w_esum = w_esum + (EW+1)'(1);
    end
    w_sat3 = w_esum[EW] | r_psat2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S         <= 1'b0;
      E         <= '0;
      F         <= '0;
      sat       <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_v2;
      S         <= r_s2;
      E         <= w_sat3 ? {EW{1'b1}} : w_esum[EW-1:0];
      F         <= w_sat3 ? {FW{1'b1}} : w_f3;
      sat       <= w_sat3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && sat && (sat_cnt != {CW{1'b1}})) begin
      sat_cnt <= sat_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for fpcvt_pipe: default (12/3/4) and wide (20/4/4) instances,
// checked against an arithmetic reference model on every handshake.
module tb_fpcvt_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic iv0, ir0, rnd0, ov0, or0, s0, sat0, clr0;
  logic [11:0] d0;
  logic [2:0]  e0;
  logic [3:0]  f0;
  logic [15:0] cnt0;

  logic iv1, ir1, rnd1, ov1, or1, s1, sat1, clr1;
  logic [19:0] d1;
  logic [3:0]  e1, f1;
  logic [15:0] cnt1;

  fpcvt_pipe dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .D(d0),
    .rnd_en(rnd0), .out_valid(ov0), .out_ready(or0), .S(s0), .E(e0),
    .F(f0), .sat(sat0), .sat_cnt(cnt0), .clr(clr0)
  );

  fpcvt_pipe #(.W(20), .EW(4), .FW(4), .CW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .D(d1),
    .rnd_en(rnd1), .out_valid(ov1), .out_ready(or1), .S(s1), .E(e1),
    .F(f1), .sat(sat1), .sat_cnt(cnt1), .clr(clr1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int q[2][$];
  int cnt_m[2];
  bit st[2];
  int prevw[2];

  function automatic int pk(int sat, int s, int e, int f);
    return (sat << 17) | (s << 16) | (e << 8) | f;
  endfunction

  // Value = F * 2^E: E is the smallest shift that fits |D| into FW bits.
  function automatic int model(longint d, bit rnd, int w, int ew, int fw);
    longint mag, f;
    int e, s, sat;
    s   = (d < 0) ? 1 : 0;
    mag = (d < 0) ? -d : d;
    sat = 0;
    if (mag == (longint'(1) << (w - 1))) begin
      mag = mag - 1;
      sat = 1;
    end
    e = 0;
    while ((mag >> e) >= (longint'(1) << fw)) e++;
    f = mag >> e;
    if (rnd && e > 0 && ((mag >> (e - 1)) & 1) == 1) f++;
    if (f == (longint'(1) << fw)) begin
      f = f >> 1;
      e++;
    end
    if (e > (1 << ew) - 1) sat = 1;
    if (sat != 0) begin
      e = (1 << ew) - 1;
      f = (longint'(1) << fw) - 1;
    end
    return pk(sat, s, e, int'(f));
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int k, input bit iv, input bit ir, input bit ov,
                     input bit orr, input bit clr, input int word,
                     input longint dval, input bit rnd, input int cnt_act,
                     input int w, input int ew, input int fw);
    int exp_w;
    bit xfer_sat;
    chk($sformatf("u%0d sat_cnt", k), cnt_act, cnt_m[k]);
    chk($sformatf("u%0d in_ready", k), ir, !ov || orr);
    if (st[k]) chk($sformatf("u%0d stall_hold", k), ov ? word : -1, prevw[k]);
    st[k]    = ov && !orr;
    prevw[k] = word;
    xfer_sat = 1'b0;
    if (ov && orr) begin
      chk($sformatf("u%0d out_pending", k), q[k].size() > 0, 1);
      if (q[k].size() > 0) begin
        exp_w = q[k].pop_front();
        chk($sformatf("u%0d out_word", k), word, exp_w);
        xfer_sat = exp_w[17];
      end
    end
    if (clr) cnt_m[k] = 0;
    else if (xfer_sat && cnt_m[k] < 65535) cnt_m[k]++;
    if (iv && ir) q[k].push_back(model(dval, rnd, w, ew, fw));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        q[k].delete();
        cnt_m[k] = 0;
        st[k]    = 1'b0;
      end
      chk("rst u0 out_valid", ov0, 0);
      chk("rst u0 in_ready", ir0, 1);
      chk("rst u0 word", pk(sat0, s0, e0, f0), 0);
      chk("rst u0 sat_cnt", cnt0, 0);
      chk("rst u1 out_valid", ov1, 0);
    end else begin
      mon(0, iv0, ir0, ov0, or0, clr0, pk(sat0, s0, e0, f0),
          longint'($signed(d0)), rnd0, int'(cnt0), 12, 3, 4);
      mon(1, iv1, ir1, ov1, or1, clr1, pk(sat1, s1, e1, f1),
          longint'($signed(d1)), rnd1, int'(cnt1), 20, 4, 4);
    end
  end

  // Single sample through the idle default pipeline with a literal expectation.
  task automatic direct(input string nm, input int d, input bit rnd, input int exp_w);
    int lat;
    @(posedge clk); #2;
    d0 = 12'(d); rnd0 = rnd; iv0 = 1'b1;
    @(posedge clk); #2;
    iv0 = 1'b0;
    lat = 1;
    while (!ov0 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, 3);
    chk({nm, " word"}, pk(sat0, s0, e0, f0), exp_w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int vals[10];
    int idx;
    rst_n = 1'b0;
    iv0 = 0; rnd0 = 0; or0 = 1; clr0 = 0; d0 = '0;
    iv1 = 0; rnd1 = 0; or1 = 1; clr1 = 0; d1 = '0;

    chk("model 422", model(422, 0, 12, 3, 4), pk(0, 0, 5, 13));
    chk("model -1", model(-1, 0, 12, 3, 4), pk(0, 1, 0, 1));
    chk("model 125 rnd", model(125, 1, 12, 3, 4), pk(0, 0, 4, 8));
    chk("model w20 max trunc", model(524287, 0, 20, 4, 4), pk(0, 0, 15, 15));
    chk("model w20 max rnd", model(524287, 1, 20, 4, 4), pk(1, 0, 15, 15));

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    direct("d422", 422, 0, pk(0, 0, 5, 13));
    direct("d-422", -422, 0, pk(0, 1, 5, 13));
    direct("d0", 0, 0, pk(0, 0, 0, 0));
    direct("d15", 15, 0, pk(0, 0, 0, 15));
    direct("d45r", 45, 1, pk(0, 0, 2, 11));
    direct("d46r", 46, 1, pk(0, 0, 2, 12));
    direct("d125r", 125, 1, pk(0, 0, 4, 8));
    direct("d125t", 125, 0, pk(0, 0, 3, 15));
    direct("d2047r", 2047, 1, pk(1, 0, 7, 15));
    direct("d-2048", -2048, 0, pk(1, 1, 7, 15));
    @(posedge clk); #1;
    chk("sat_cnt after two", cnt0, 2);
    #1 clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("sat_cnt cleared", cnt0, 0);

    // Back-pressure: out_ready 1,0,0 repeating while streaming 10 values.
    for (int i = 0; i < 10; i++) vals[i] = $urandom_range(0, 4095);
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #2;
      or0  = (c % 3 == 0);
      iv0  = (idx < 10);
      d0   = 12'(vals[(idx < 10) ? idx : 0]);
      rnd0 = c[0];
      #1;
      if (iv0 && ir0) idx++;
    end
    @(posedge clk); #2;
    iv0 = 1'b0; or0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("bp all accepted", idx, 10);
    chk("bp drained", q[0].size(), 0);

    // Reset with three samples in flight and one saturating result counted.
    @(posedge clk); #2;
    iv0 = 1'b1; rnd0 = 1'b0; d0 = 12'h800;
    @(posedge clk); #2 d0 = 12'd1000;
    @(posedge clk); #2 d0 = 12'd7;
    @(posedge clk); #2 d0 = 12'd300;
    @(posedge clk); #2;
    iv0 = 1'b0;
    chk("midrst pre out_valid", ov0, 1);
    chk("midrst pre sat_cnt", cnt0 > 0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", ov0, 0);
    chk("midrst sat_cnt", cnt0, 0);
    chk("midrst in_ready", ir0, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("post-reset no stale out", ov0, 0);
    end

    // Exhaustive sweep, default widths, both modes.
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4096; d++) begin
        @(posedge clk); #2;
        iv0 = 1'b1; d0 = 12'(d); rnd0 = r[0];
      end
    end
    @(posedge clk); #2 iv0 = 1'b0;

    // Wide instance: boundaries plus random fill, both modes.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6000; i++) begin
        @(posedge clk); #2;
        iv1  = 1'b1;
        rnd1 = r[0];
        if (i < 40)      d1 = 20'(i - 20);
        else if (i == 40) d1 = 20'h80000;
        else if (i == 41) d1 = 20'h7FFFF;
        else if (i == 42) d1 = 20'h7FFFE;
        else if (i < 62)  d1 = 20'((1 << (i - 43)) - 1);
        else              d1 = 20'($urandom);
      end
    end
    @(posedge clk); #2 iv1 = 1'b0;

    // Random traffic with random stalls and clears on both instances.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      iv0 = ($urandom % 4) != 0; or0 = ($urandom % 3) != 0;
      d0 = 12'($urandom); rnd0 = 1'($urandom); clr0 = ($urandom % 64) == 0;
      iv1 = ($urandom % 4) != 0; or1 = ($urandom % 3) != 0;
      d1 = 20'($urandom); rnd1 = 1'($urandom); clr1 = ($urandom % 64) == 0;
    end
    @(posedge clk); #2;
    iv0 = 0; or0 = 1; clr0 = 0;
    iv1 = 0; or1 = 1; clr1 = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("final u0 drained", q[0].size(), 0);
    chk("final u1 drained", q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
